mdu_iterative: RTL and testbench
================================

# mdu_iterative

Multi-cycle multiply/divide unit in the EXE stage of the MIPS pipeline. It performs MULT/MULTU/MUL through a two-stage registered multiplier and DIV/DIVU through a 32-iteration restoring divider. It stalls the pipeline while busy and owns the architectural HI/LO registers. It produces the MUL_Out operand that the ALU's MUL path selects, and the HI/LO values that the MFHI/MFLO datapath reads.

## Interface
- No parameters; datapath is fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- EXE_ResultA  in  32  operand rs; dividend for DIV/DIVU.
- EXE_ResultB  in  32  operand rt; divisor for DIV/DIVU.
- EXE_MDUOp  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MUL; values are held stable by the pipeline while EXE_Stall is high.
- EXE_Flush  in  1  kills the EXE instruction (exception or eret).
- MUL_Out  out  32  low word of the product; valid in the DONE cycle of op 7.
- HI_Out  out  32  architectural HI register.
- LO_Out  out  32  architectural LO register.
- EXE_Stall  out  1  combinational; high while the EXE instruction must be held.

## Operation
States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - Ops 1, 2, 7 go to MUL; ops 3, 4 go to DIV.
  - In either case, latch the operands, the signedness and the op in the same edge.
  - For DIV, also latch abs(A), abs(B), quotient sign = A[31]^B[31] and remainder sign = A[31].
  - Ops 5 and 6 write HI or LO with EXE_ResultA at the edge unless EXE_Flush; they cause no stall and no state change.
- **MUL**
  - One cycle.
  - The registered 64-bit product (signed for 1 and 7, unsigned for 2) goes to the result register.
  - Then go to DONE.
- **DIV**
  - 32 cycles, counted by a 5-bit counter from 0 to 31.
  - Each cycle shifts the remainder/quotient pair left by one and subtracts the divisor; the quotient bit is set if the result is non-negative.
  - After the counter reaches 31, go to DONE.
  - Apply sign fix-up on entry to DONE: negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
- **DONE**
  - One cycle; EXE_Stall is low, so the pipeline advances.
  - At the edge, if !EXE_Flush: ops 1–4 write HI ← high word/remainder and LO ← low word/quotient; op 7 writes nothing.
  - Unconditionally go to IDLE; the still-present op is never restarted.
- **EXE_Stall** = (IDLE && op∈{1,2,3,4,7}) || MUL || DIV.
- **EXE_Flush in MUL or DIV:** go to IDLE next edge and drop the result. HI/LO are unchanged.
- **Divide by zero:** no trap. The restoring algorithm output is the defined result: DIVU gives quotient 0xFFFFFFFF and remainder A. DIV then applies the normal sign fix-up to that output.
- **DIV 0x80000000 / 0xFFFFFFFF:** quotient 0x80000000, remainder 0.
- **MUL_Out** is the low word of the result register; it is 0 outside DONE.

## Timing
- **Reset (asynchronous, resetn low):** state IDLE, counter 0, HI_Out 0, LO_Out 0, result register 0, MUL_Out 0. EXE_Stall is 0 while reset is asserted and the op is NOP.
- **Multiply latency:** IDLE (stall) → MUL (stall) → DONE (no stall). The instruction occupies EXE for 3 cycles; HI/LO are visible the cycle after DONE.
- **Divide latency:** IDLE + 32 DIV cycles + DONE = 34 cycles in EXE.
- **Back-to-back:** a new multicycle op arriving in the cycle after DONE starts from IDLE with no bubble.
- **MTHI/MTLO directly after a MULT:** the MTHI/MTLO write lands one edge after the MULT's HI/LO write, so program order is preserved.
- **EXE_Flush during IDLE with a multicycle op:** no state change. EXE_Stall is still driven high from the decode equation; the pipeline's flush priority clears EXE.
- **resetn asserted mid-DIV:** immediate abort; outputs take their reset values.

## Test plan
- **MULT:** 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. EXE_Stall high exactly 2 cycles.
- **MULTU** on the same operands → HI=0x00000002, LO=0xFFFFFFFA. **MUL** 7×6 → MUL_Out=42 in DONE, HI/LO unchanged.
- **DIV:** −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. **DIVU:** 100/7 → LO=14, HI=2. Stall high exactly 33 cycles.
- **Corner divides:**
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- **Flush:** EXE_Flush at DIV cycle 10 → IDLE next cycle, HI/LO keep their prior values. Flush in DONE → no write.
- **Mid-divide reset, then move:** resetn pulsed low mid-DIV → HI=LO=0, state IDLE. Then MTHI 0x1234 → HI_Out=0x1234 next cycle with no stall.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the EXE stage: two-stage multiplier,
// 32-step restoring divider, and the architectural HI/LO registers.
module mdu_iterative (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] EXE_ResultA,
   input  logic [31:0] EXE_ResultB,
   input  logic [2:0]  EXE_MDUOp,
   input  logic        EXE_Flush,
   output logic [31:0] MUL_Out,
   output logic [31:0] HI_Out,
   output logic [31:0] LO_Out,
   output logic        EXE_Stall
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_MUL   = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic        mul_signed_q;
   logic [31:0] mul_a_q, mul_b_q;
   logic [31:0] rem_q, quo_q, divisor_q;
   logic        q_neg_q, r_neg_q;
   logic [4:0]  count_q;
   logic [63:0] result_q;
   logic [31:0] hi_q, lo_q;

   logic        is_mul_op, is_div_op, op_signed, start_mul, start_div;
   logic [31:0] abs_a, abs_b;
   logic [63:0] mul_ext_a, mul_ext_b, product;
   logic [32:0] rem_shift;
   logic        div_ok;
   logic [31:0] rem_sub, rem_next, quo_next, quo_fixed, rem_fixed;

   assign is_mul_op = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_MULTU) || (EXE_MDUOp == OP_MUL);
   assign is_div_op = (EXE_MDUOp == OP_DIV)  || (EXE_MDUOp == OP_DIVU);
   assign op_signed = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_MUL)   || (EXE_MDUOp == OP_DIV);
   assign start_mul = (state_q == S_IDLE) && !EXE_Flush && is_mul_op;
   assign start_div = (state_q == S_IDLE) && !EXE_Flush && is_div_op;

   // Magnitudes for the unsigned core; 0x80000000 maps onto itself, which is correct as unsigned.
   assign abs_a = (op_signed && EXE_ResultA[31]) ? (~EXE_ResultA + 32'd1) : EXE_ResultA;
   assign abs_b = (op_signed && EXE_ResultB[31]) ? (~EXE_ResultB + 32'd1) : EXE_ResultB;

   assign mul_ext_a = {{32{mul_signed_q & mul_a_q[31]}}, mul_a_q};
   assign mul_ext_b = {{32{mul_signed_q & mul_b_q[31]}}, mul_b_q};
   assign product   = mul_ext_a * mul_ext_b;

   // One restoring step; the difference always fits in 32 bits when it is kept.
   assign rem_shift = {rem_q, quo_q[31]};
   assign div_ok    = rem_shift >= {1'b0, divisor_q};
   assign rem_sub   = rem_shift[31:0] - divisor_q;
   assign rem_next  = div_ok ? rem_sub : rem_shift[31:0];
   assign quo_next  = {quo_q[30:0], div_ok};
   assign quo_fixed = q_neg_q ? (~quo_next + 32'd1) : quo_next;
   assign rem_fixed = r_neg_q ? (~rem_next + 32'd1) : rem_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      EXE_Stall = 1'b0;
      case (state_q)
         S_IDLE: begin
            EXE_Stall = is_mul_op || is_div_op;
            if (start_mul)      state_d = S_MUL;
            else if (start_div) state_d = S_DIV;
         end
         S_MUL: begin
            EXE_Stall = 1'b1;
            state_d   = EXE_Flush ? S_IDLE : S_DONE;
         end
         S_DIV: begin
            EXE_Stall = 1'b1;
            if (EXE_Flush)             state_d = S_IDLE;
            else if (count_q == 5'd31) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q         <= 3'd0;
         mul_signed_q <= 1'b0;
         mul_a_q      <= 32'd0;
         mul_b_q      <= 32'd0;
         rem_q        <= 32'd0;
         quo_q        <= 32'd0;
         divisor_q    <= 32'd0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         count_q      <= 5'd0;
         result_q     <= 64'd0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_mul || start_div) begin
                  op_q         <= EXE_MDUOp;
                  mul_signed_q <= op_signed;
                  mul_a_q      <= EXE_ResultA;
                  mul_b_q      <= EXE_ResultB;
               end
               if (start_div) begin
                  rem_q     <= 32'd0;
                  quo_q     <= abs_a;
                  divisor_q <= abs_b;
                  q_neg_q   <= op_signed & (EXE_ResultA[31] ^ EXE_ResultB[31]);
                  r_neg_q   <= op_signed & EXE_ResultA[31];
                  count_q   <= 5'd0;
               end
               if (!EXE_Flush && EXE_MDUOp == OP_MTHI) hi_q <= EXE_ResultA;
               if (!EXE_Flush && EXE_MDUOp == OP_MTLO) lo_q <= EXE_ResultA;
            end
            S_MUL: begin
               if (!EXE_Flush) result_q <= product;
            end
            S_DIV: begin
               if (!EXE_Flush) begin
                  rem_q   <= rem_next;
                  quo_q   <= quo_next;
                  count_q <= count_q + 5'd1;
                  if (count_q == 5'd31) result_q <= {rem_fixed, quo_fixed};
               end
            end
            S_DONE: begin
               if (!EXE_Flush && op_q >= OP_MULT && op_q <= OP_DIVU) begin
                  hi_q <= result_q[63:32];
                  lo_q <= result_q[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign HI_Out  = hi_q;
   assign LO_Out  = lo_q;
   assign MUL_Out = (state_q == S_DONE) ? result_q[31:0] : 32'd0;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, randomized ops
// against an arithmetic reference model, and flush/reset sequences.
module tb_mdu_iterative;

   localparam logic [2:0] OP_NOP = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                          OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_MUL = 3'd7;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] EXE_ResultA = '0;
   logic [31:0] EXE_ResultB = '0;
   logic [2:0]  EXE_MDUOp = OP_NOP;
   logic        EXE_Flush = 1'b0;
   logic [31:0] MUL_Out, HI_Out, LO_Out;
   logic        EXE_Stall;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_hi = '0, model_lo = '0;

   mdu_iterative dut (
      .clk(clk), .resetn(resetn),
      .EXE_ResultA(EXE_ResultA), .EXE_ResultB(EXE_ResultB),
      .EXE_MDUOp(EXE_MDUOp), .EXE_Flush(EXE_Flush),
      .MUL_Out(MUL_Out), .HI_Out(HI_Out), .LO_Out(LO_Out), .EXE_Stall(EXE_Stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] hi, lo, mul;
      int          stalls;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: architectural results straight from integer arithmetic.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] mul, output int stalls);
      logic [63:0] p;
      longint sa, sb;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      mul = 32'd0;
      stalls = 0;
      case (op)
         OP_MULT, OP_MUL: begin
            p = 64'(sa * sb);
            stalls = 2;
            if (op == OP_MUL) mul = p[31:0];
            else begin model_hi = p[63:32]; model_lo = p[31:0]; end
         end
         OP_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            stalls = 2;
            model_hi = p[63:32]; model_lo = p[31:0];
         end
         OP_DIV: begin
            stalls = 33;
            if (b == 0) begin
               model_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               model_hi = a;
            end else begin
               model_lo = 32'(sa / sb);
               model_hi = 32'(sa % sb);
            end
         end
         OP_DIVU: begin
            stalls = 33;
            if (b == 0) begin model_lo = 32'hFFFF_FFFF; model_hi = a; end
            else begin model_lo = a / b; model_hi = a % b; end
         end
         OP_MTHI: model_hi = a;
         OP_MTLO: model_lo = a;
         default: ;
      endcase
   endtask

   // Called at a negedge; returns at the negedge after the instruction leaves EXE.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic [31:0] mul_out);
      EXE_MDUOp = op; EXE_ResultA = a; EXE_ResultB = b;
      stalls = 0;
      #1;
      while (EXE_Stall === 1'b1 && stalls < 100) begin
         @(posedge clk); @(negedge clk); #1;
         stalls++;
      end
      mul_out = MUL_Out;
      @(posedge clk); #1;
      EXE_MDUOp = OP_NOP;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input logic [31:0] exp_mul,
                                input int exp_stalls);
      int st;
      logic [31:0] mo;
      issue(op, a, b, st, mo);
      check({tag, " stalls"}, 32'(st), 32'(exp_stalls));
      check({tag, " HI"}, HI_Out, exp_hi);
      check({tag, " LO"}, LO_Out, exp_lo);
      if (op == OP_MUL) check({tag, " MUL_Out"}, mo, exp_mul);
   endtask

   vec_t vecs[11];

   initial begin
      int st;
      logic [31:0] mo, exp_mul, a, b, hi_keep, lo_keep;
      logic [2:0] op;
      int exp_st;

      vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 2};
      vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 32'd0, 2};
      vecs[2]  = '{OP_MUL,   32'd7, 32'd6, 32'h0000_0002, 32'hFFFF_FFFA, 32'd42, 2};
      vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 33};
      vecs[4]  = '{OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 32'd0, 33};
      vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 33};
      vecs[6]  = '{OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'd0, 33};
      vecs[7]  = '{OP_MTHI,  32'h0000_CAFE, 32'd0, 32'h0000_CAFE, 32'hFFFF_FFFF, 32'd0, 0};
      vecs[8]  = '{OP_MTLO,  32'h0000_BEEF, 32'd0, 32'h0000_CAFE, 32'h0000_BEEF, 32'd0, 0};
      vecs[9]  = '{OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32'd0, 33};
      vecs[10] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, 32'd0, 33};

      // Reset state
      #12;
      check("reset HI", HI_Out, 32'd0);
      check("reset LO", LO_Out, 32'd0);
      check("reset MUL_Out", MUL_Out, 32'd0);
      check("reset stall", 32'(EXE_Stall), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 11; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                       vecs[i].hi, vecs[i].lo, vecs[i].mul, vecs[i].stalls);
      model_hi = vecs[10].hi;
      model_lo = vecs[10].lo;

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 7));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         model_op(op, a, b, exp_mul, exp_st);
         run_and_check($sformatf("rnd%0d op%0d", i, op), op, a, b, model_hi, model_lo, exp_mul, exp_st);
      end

      // Flush at DIV cycle 10: back to IDLE, no write
      hi_keep = HI_Out; lo_keep = LO_Out;
      EXE_MDUOp = OP_DIV; EXE_ResultA = 32'd1000; EXE_ResultB = 32'd3;
      st = 0;
      #1;
      while (EXE_Stall === 1'b1 && st < 10) begin
         @(posedge clk); @(negedge clk); #1; st++;
      end
      EXE_Flush = 1'b1;
      @(posedge clk); #1;
      EXE_Flush = 1'b0; EXE_MDUOp = OP_NOP;
      @(negedge clk); #1;
      check("div flush stall", 32'(EXE_Stall), 32'd0);
      repeat (3) @(negedge clk);
      check("div flush HI", HI_Out, hi_keep);
      check("div flush LO", LO_Out, lo_keep);

      // Flush in DONE: no write
      EXE_MDUOp = OP_MULT; EXE_ResultA = 32'd5; EXE_ResultB = 32'd5;
      st = 0;
      #1;
      while (EXE_Stall === 1'b1 && st < 100) begin
         @(posedge clk); @(negedge clk); #1; st++;
      end
      check("done flush stalls", 32'(st), 32'd2);
      EXE_Flush = 1'b1;
      @(posedge clk); #1;
      EXE_Flush = 1'b0; EXE_MDUOp = OP_NOP;
      @(negedge clk);
      check("done flush HI", HI_Out, hi_keep);
      check("done flush LO", LO_Out, lo_keep);

      // Flush during IDLE: stall still decoded, no state change
      EXE_MDUOp = OP_DIV; EXE_ResultA = 32'd9; EXE_ResultB = 32'd2; EXE_Flush = 1'b1;
      #1;
      check("idle flush stall", 32'(EXE_Stall), 32'd1);
      @(posedge clk); #1;
      EXE_Flush = 1'b0; EXE_MDUOp = OP_NOP;
      @(negedge clk); #1;
      check("idle flush no start", 32'(EXE_Stall), 32'd0);
      @(negedge clk);

      // Reset mid-divide, then MTHI
      run_and_check("pre-reset MTLO", OP_MTLO, 32'h5555_0001, 32'd0, hi_keep, 32'h5555_0001, 32'd0, 0);
      EXE_MDUOp = OP_DIVU; EXE_ResultA = 32'd77; EXE_ResultB = 32'd4;
      repeat (6) @(negedge clk);
      EXE_MDUOp = OP_NOP;
      resetn = 1'b0;
      #1;
      check("mid-div reset HI", HI_Out, 32'd0);
      check("mid-div reset LO", LO_Out, 32'd0);
      check("mid-div reset stall", 32'(EXE_Stall), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_and_check("post-reset MTHI", OP_MTHI, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'd0, 32'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
